// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART <-> ALU command sequencer.
package uart_pkg;

  // Sequencer states: opcode fetch, four operand bytes, execute, two TX bytes.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    GET_A0  = 4'd1,
    GET_A1  = 4'd2,
    GET_B0  = 4'd3,
    GET_B1  = 4'd4,
    EXEC    = 4'd5,
    TX_LO   = 4'd6,
    WAIT_LO = 4'd7,
    TX_HI   = 4'd8,
    WAIT_HI = 4'd9
  } seq_state_t;

  localparam int FRAME_LEN   = 5;
  localparam int DEF_NUM_OPS = 5;
  localparam int DEF_OP_W    = 3;

endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap counter: clears on demand, counts while enabled, saturates
// at its last value so a long stall can never wrap back into range.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Gap counter: clear has priority, then saturating count while enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Command sequencer: gathers a 5-byte frame (opcode, A lo/hi, B lo/hi) from
// the UART receiver, presents operands to the external ALU, captures the
// result and returns it over the UART transmitter, low byte first.
module uart_alu_sequencer
  import uart_pkg::*;
#(
  parameter int NUM_OPS        = DEF_NUM_OPS,
  parameter int OP_W           = DEF_OP_W,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_ready,
  input  logic [15:0]     alu_result,
  input  logic            tx_busy,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  output logic            busy,
  output logic            cmd_done,
  output logic            cmd_error
);

  // One extra bit so NUM_OPS == 2**OP_W still compares correctly.
  localparam logic [OP_W:0] OP_LIMIT = (OP_W+1)'(NUM_OPS);

  seq_state_t      state_r, state_s;
  logic [15:0]     alu_a_r, alu_b_r, res_r;
  logic [OP_W-1:0] alu_op_r;
  logic [7:0]      tx_data_r;
  logic            seen_busy_r, seen_busy_s;
  logic            op_err_r, op_err_s;
  logic            cmd_done_r, cmd_done_s;
  logic            timeout_s;
  logic            accept_s;
  logic            tx_start_s;
  logic            in_get_s;
  logic            op_ok_s;
  logic            expired_s;
  logic [OP_W:0]   op_ext_s;

  assign op_ext_s = {1'b0, rx_data[OP_W-1:0]};
  assign op_ok_s  = (op_ext_s < OP_LIMIT);
  assign in_get_s = (state_r == GET_A0) || (state_r == GET_A1) ||
                    (state_r == GET_B0) || (state_r == GET_B1);

  // The gap timer only runs while a frame is partially collected and restarts
  // on every accepted byte, so an idle link never raises a timeout.
  gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept_s | ~in_get_s),
    .enable  (in_get_s),
    .expired (expired_s)
  );

  // Next-state and strobe decode; a byte arriving on the expiry cycle wins.
  always_comb begin
    state_s     = state_r;
    seen_busy_s = seen_busy_r;
    op_err_s    = 1'b0;
    cmd_done_s  = 1'b0;
    timeout_s   = 1'b0;
    accept_s    = 1'b0;
    tx_start_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_ready) begin
          if (op_ok_s) begin
            accept_s = 1'b1;
            state_s  = GET_A0;
          end else begin
            op_err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GET_A0, GET_A1, GET_B0, GET_B1: begin
        if (rx_ready) begin
          accept_s = 1'b1;
          case (state_r)
            GET_A0:  state_s = GET_A1;
            GET_A1:  state_s = GET_B0;
            GET_B0:  state_s = GET_B1;
            default: state_s = EXEC;
          endcase
        end else if (expired_s) begin
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      EXEC: begin
        seen_busy_s = 1'b0;
        state_s     = TX_LO;
      end
      TX_LO, TX_HI: begin
        seen_busy_s = 1'b0;
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          state_s    = (state_r == TX_LO) ? WAIT_LO : WAIT_HI;
        end else begin
          state_s = state_r;
        end
      end
      WAIT_LO, WAIT_HI: begin
        seen_busy_s = seen_busy_r | tx_busy;
        if (seen_busy_r && !tx_busy) begin
          seen_busy_s = 1'b0;
          if (state_r == WAIT_LO) begin
            state_s = TX_HI;
          end else begin
            cmd_done_s = 1'b1;
            state_s    = IDLE;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        seen_busy_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State, operand, result and TX byte registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      alu_a_r     <= 16'h0000;
      alu_b_r     <= 16'h0000;
      alu_op_r    <= {OP_W{1'b0}};
      res_r       <= 16'h0000;
      tx_data_r   <= 8'h00;
      seen_busy_r <= 1'b0;
      op_err_r    <= 1'b0;
      cmd_done_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      seen_busy_r <= seen_busy_s;
      op_err_r    <= op_err_s;
      cmd_done_r  <= cmd_done_s;
      case (state_r)
        IDLE:   if (accept_s) alu_op_r <= rx_data[OP_W-1:0];
        GET_A0: if (accept_s) alu_a_r[7:0]  <= rx_data;
        GET_A1: if (accept_s) alu_a_r[15:8] <= rx_data;
        GET_B0: if (accept_s) alu_b_r[7:0]  <= rx_data;
        GET_B1: if (accept_s) alu_b_r[15:8] <= rx_data;
        EXEC: begin
          // Low byte is staged together with the result so it is already
          // stable on the cycle tx_start is raised.
          res_r     <= alu_result;
          tx_data_r <= alu_result[7:0];
        end
        WAIT_LO: if (state_s == TX_HI) tx_data_r <= res_r[15:8];
        default: ;
      endcase
    end
  end

  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign tx_data   = tx_data_r;
  assign tx_start  = tx_start_s;
  assign busy      = (state_r != IDLE);
  assign cmd_done  = cmd_done_r;
  assign cmd_error = op_err_r | timeout_s;

endmodule
